cache_line_mem_if: RTL

//  Downstream stage of the 4-way cache controller. Replaces the fixed-delay EVICT/ALLOCATE model.
//  - Accepts one line-level request: optional 512-bit victim write-back, then optional line fill.
//  - Serialises each request into 16 single-word beats on a 32-bit handshaked memory bus.
//  - Returns the filled line as 512 bits. Word k of a line is bits [32k+31:32k], at address base+4k.

---
 rtl/cache_pkg.sv | 31 +++
 rtl/cache_line_mem_if_if.sv | 37 +++
 rtl/line_beat_serdes.sv | 41 ++++
 rtl/cache_line_mem_if.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: constants, line/word types and FSM encoding shared by the
// 4-way cache controller and its line-level memory interface stage.
package cache_pkg;

    localparam int ADDR_W         = 32;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 16;
    localparam int OFFSET_BITS    = 6;
    localparam int LINE_W         = WORDS_PER_LINE * WORD_W;
    localparam int BEAT_W         = $clog2(WORDS_PER_LINE);
    localparam int TAG_W          = ADDR_W - OFFSET_BITS;

    // Word k of a line sits at bits [32k+31:32k].
    typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Byte address of one beat; the line offset comes only from the beat.
    function automatic logic [ADDR_W-1:0] beat_addr(
        input logic [TAG_W-1:0]  line,
        input logic [BEAT_W-1:0] beat
    );
        return {line, beat, 2'b00};
    endfunction

endpackage

// File: rtl/cache_line_mem_if_if.sv
// cache_line_mem_if_if: line request/response handshake plus the 32-bit
// beat bus. master = cache controller and memory; slave = this stage.
interface cache_line_mem_if_if;
    import cache_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wb;
    logic [ADDR_W-1:0] req_wb_addr;
    logic [LINE_W-1:0] req_wb_data;
    logic              req_fill;
    logic [ADDR_W-1:0] req_fill_addr;
    logic              resp_valid;
    logic [LINE_W-1:0] resp_data;
    logic              busy;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;

    modport master (
        output req_valid, req_wb, req_wb_addr, req_wb_data,
        output req_fill, req_fill_addr, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_data, busy,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_wb, req_wb_addr, req_wb_data,
        input  req_fill, req_fill_addr, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_data, busy,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/line_beat_serdes.sv
// line_beat_serdes: beat counter and fill line buffer. Selects the write
// word of a line and inserts read words into the buffer.
// Ports: beat_adv/fill_wr/rdata in; sel_line/sel_idx -> sel_word;
// beat_cnt, beat_nxt and line out.
module line_beat_serdes
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              beat_adv,
    input  logic              fill_wr,
    input  logic [WORD_W-1:0] rdata,
    input  line_t             sel_line,
    input  logic [BEAT_W-1:0] sel_idx,
    output logic [BEAT_W-1:0] beat_cnt,
    output logic [BEAT_W-1:0] beat_nxt,
    output logic [WORD_W-1:0] sel_word,
    output line_t             line
);

    // Wraps 15 -> 0 by width; no carry is kept.
    assign beat_nxt = beat_cnt + BEAT_W'(1);
    assign sel_word = sel_line[sel_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (beat_adv) begin
            beat_cnt <= beat_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line <= '0;
        end else if (fill_wr) begin
            line[beat_cnt] <= rdata;
        end
    end

endmodule

// File: rtl/cache_line_mem_if.sv
// cache_line_mem_if: serialises one line request (optional write-back,
// then optional fill) into 16-beat bursts on the 32-bit memory bus.
// Ports: clk, rst (async, active-high); bus = request/response
// handshake and memory beat bus (slave view).
module cache_line_mem_if
    import cache_pkg::*;
(
    input logic                clk,
    input logic                rst,
    cache_line_mem_if_if.slave bus
);

    state_t              state;
    state_t              state_n;
    logic                fill_q;
    logic [TAG_W-1:0]    wb_tag_q;
    logic [TAG_W-1:0]    fill_tag_q;
    line_t               wb_data_q;

    logic                accept;
    logic                fire;
    logic                last;
    line_t               sel_line;
    logic [BEAT_W-1:0]   sel_idx;
    logic [WORD_W-1:0]   sel_word;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [BEAT_W-1:0]   beat_nxt;
    line_t               line;

    logic                req_n;
    logic                we_n;
    logic                ready_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [WORD_W-1:0]   wdata_n;

    assign accept = bus.req_valid && bus.req_ready;
    assign fire   = bus.mem_req && bus.mem_ack;
    assign last   = beat_cnt == BEAT_W'(WORDS_PER_LINE - 1);

    // Beat 0 of a write-back comes straight from the request bus.
    assign sel_line = (state == ST_IDLE) ? line_t'(bus.req_wb_data)
                                         : wb_data_q;
    assign sel_idx  = (state == ST_IDLE) ? '0 : beat_nxt;

    assign bus.busy       = state != ST_IDLE;
    assign bus.resp_valid = state == ST_DONE;
    assign bus.resp_data  = line;

    line_beat_serdes u_serdes (
        .clk      (clk),
        .rst      (rst),
        .beat_adv (fire),
        .fill_wr  (fire && state == ST_FILL),
        .rdata    (bus.mem_rdata),
        .sel_line (sel_line),
        .sel_idx  (sel_idx),
        .beat_cnt (beat_cnt),
        .beat_nxt (beat_nxt),
        .sel_word (sel_word),
        .line     (line)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q     <= 1'b0;
            wb_tag_q   <= '0;
            fill_tag_q <= '0;
            wb_data_q  <= '0;
        end else if (accept) begin
            fill_q     <= bus.req_fill;
            wb_tag_q   <= bus.req_wb_addr[ADDR_W-1:OFFSET_BITS];
            fill_tag_q <= bus.req_fill_addr[ADDR_W-1:OFFSET_BITS];
            wb_data_q  <= line_t'(bus.req_wb_data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        req_n   = bus.mem_req;
        we_n    = bus.mem_we;
        addr_n  = bus.mem_addr;
        wdata_n = bus.mem_wdata;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.req_wb) begin
                        state_n = ST_WB;
                        req_n   = 1'b1;
                        we_n    = 1'b1;
                        addr_n  = beat_addr(
                            bus.req_wb_addr[ADDR_W-1:OFFSET_BITS], '0);
                        wdata_n = sel_word;
                    end else if (bus.req_fill) begin
                        state_n = ST_FILL;
                        req_n   = 1'b1;
                        we_n    = 1'b0;
                        addr_n  = beat_addr(
                            bus.req_fill_addr[ADDR_W-1:OFFSET_BITS], '0);
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_WB: begin
                if (fire) begin
                    if (!last) begin
                        addr_n  = beat_addr(wb_tag_q, beat_nxt);
                        wdata_n = sel_word;
                    end else if (fill_q) begin
                        state_n = ST_FILL;
                        we_n    = 1'b0;
                        addr_n  = beat_addr(fill_tag_q, '0);
                    end else begin
                        state_n = ST_DONE;
                        req_n   = 1'b0;
                        we_n    = 1'b0;
                    end
                end
            end
            ST_FILL: begin
                if (fire) begin
                    if (last) begin
                        state_n = ST_DONE;
                        req_n   = 1'b0;
                    end else begin
                        addr_n = beat_addr(fill_tag_q, beat_nxt);
                    end
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        // Registered, so ready is low through reset and rises one edge later.
        ready_n = state_n == ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.req_ready <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.req_ready <= ready_n;
            bus.mem_req   <= req_n;
            bus.mem_we    <= we_n;
            bus.mem_addr  <= addr_n;
            bus.mem_wdata <= wdata_n;
        end
    end

endmodule
